// File: rtl/fetch_stage.sv
// fetch_stage: IF-stage controller for the MIPS core.
// Owns the program counter and presents it to the instruction memory.
// Captures the returned instruction into the IF/ID pipeline register.
// Handles stall, flush, branch/jump redirect and sticky fetch faults.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_rd,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fetch_count
);

  // First byte address past the end of instruction memory.
  localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

  localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
  localparam logic [1:0] CAUSE_RANGE      = 2'b10;

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4;
  logic        pc_out_of_range;
  logic        redirect_misaligned;

  assign pc_plus4            = pc_q + 32'd4;
  assign pc_out_of_range     = (pc_q >= PC_LIMIT);
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

  // Next-state selection; priority is fault > redirect > range > stall > flush > normal.
  always_comb begin
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    fault_d       = fault_q;
    cause_d       = cause_q;
    count_d       = count_q;

    if (fault_q) begin
      // Halted: keep emitting bubbles until reset; cause stays frozen.
      id_instr_d = 32'd0;
      id_valid_d = 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over stall and flush; the wrong-path slot becomes a bubble.
      id_instr_d = 32'd0;
      id_valid_d = 1'b0;
      if (redirect_misaligned) begin
        fault_d = 1'b1;
        cause_d = CAUSE_MISALIGNED;
      end else begin
        pc_d = redirect_pc;
      end
    end else if (pc_out_of_range) begin
      id_instr_d = 32'd0;
      id_valid_d = 1'b0;
      fault_d    = 1'b1;
      cause_d    = CAUSE_RANGE;
    end else if (stall) begin
      // PC and IF/ID hold; a simultaneous flush still kills the IF/ID slot.
      if (flush) begin
        id_instr_d = 32'd0;
        id_valid_d = 1'b0;
      end
    end else if (flush) begin
      pc_d       = pc_plus4;
      id_instr_d = 32'd0;
      id_valid_d = 1'b0;
    end else begin
      pc_d          = pc_plus4;
      id_instr_d    = imem_rd;
      id_pc_d       = pc_q;
      id_pc_plus4_d = pc_plus4;
      id_valid_d    = 1'b1;
      count_d       = count_q + 32'd1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      id_instr_q    <= 32'd0;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd0;
      id_valid_q    <= 1'b0;
      fault_q       <= 1'b0;
      cause_q       <= 2'b00;
      count_q       <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      fault_q       <= fault_d;
      cause_q       <= cause_d;
      count_q       <= count_d;
    end
  end

  assign imem_pc     = pc_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_valid    = id_valid_q;
  assign fetch_fault = fault_q;
  assign fault_cause = cause_q;
  assign fetch_count = count_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF-stage controller for the MIPS core.
- Owns the program counter and drives it to the instruction memory read port (word-indexed by PC[9:2], combinational read).
- Latches the returned instruction into the IF/ID pipeline register for the decoder.
- Handles stall, flush, branch/jump redirect and fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 256, instruction memory depth in 32-bit words; legal fetch range is 0 to 4*IMEM_WORDS-4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit hold request; freezes PC and IF/ID.
- flush  in  1  squash the IF/ID contents (bubble).
- redirect_valid  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  32  branch/jump target.
- imem_pc  out  32  address to instruction memory PC input.
- imem_rd  in  32  instruction from instruction memory RD output.
- id_instr  out  32  IF/ID instruction.
- id_pc  out  32  IF/ID PC of id_instr.
- id_pc_plus4  out  32  IF/ID id_pc+4.
- id_valid  out  1  IF/ID holds a real instruction.
- fetch_fault  out  1  sticky fault flag; fetch halted.
- fault_cause  out  2  01 misaligned redirect, 10 PC out of range, 00 none.
- fetch_count  out  32  number of instructions captured into IF/ID.

Behaviour:
- Internal register pc_q; imem_pc = pc_q combinationally, no added latency. The instruction read for pc_q is captured at the same rising edge.
- Reset (async assert, any cycle, including mid-stall/redirect):
  - pc_q=RESET_PC; id_instr=0 (NOP); id_pc=0; id_pc_plus4=0; id_valid=0.
  - fetch_fault=0; fault_cause=00; fetch_count=0.
  - First capture occurs on the first rising edge after rst_n deasserts.
- Out of range: pc_q >= 4*IMEM_WORDS.
- Per-edge priority, highest first:
  1. Halted (fetch_fault=1): pc_q holds; id_instr=0; id_valid=0; fetch_count holds. Stays halted until reset.
  2. redirect_valid=1:
     - If redirect_pc[1:0]!=0: fetch_fault<=1, fault_cause<=01, pc_q holds, IF/ID bubble.
     - Else: pc_q<=redirect_pc, IF/ID bubble (id_valid<=0, id_instr<=0).
     - Redirect overrides stall and flush. id_pc/id_pc_plus4 hold on any bubble.
  3. Out of range with no redirect: fetch_fault<=1, fault_cause<=10, IF/ID bubble, pc_q holds. Checked before stall.
  4. stall=1:
     - pc_q, id_pc, id_pc_plus4, id_instr and fetch_count hold.
     - If flush=1 in the same cycle: id_valid<=0, id_instr<=0 (flush wins over stall for IF/ID only); PC still holds.
  5. flush=1 (no stall): pc_q<=pc_q+4; IF/ID bubble; fetch_count holds.
  6. Normal:
     - pc_q<=pc_q+4 (modulo 2^32).
     - id_instr<=imem_rd; id_pc<=pc_q; id_pc_plus4<=pc_q+4; id_valid<=1.
     - fetch_count<=fetch_count+1, wrapping from 0xFFFF_FFFF to 0.
- Faults latch first cause only; a later fault condition never changes fault_cause.
- pc_q[1:0] is always 00 after reset (RESET_PC must be word-aligned; this is an integration check, not a runtime check).
- All adders are 32-bit unsigned; carry out is discarded.
- No combinational path from any input to any output except imem_rd-independent imem_pc = pc_q. id_* outputs are registered.

Test Plan:
- Reset release, RESET_PC=0, imem word[i]=0x2000_0000+i:
  - Edge 1: id_pc=0, id_instr=0x2000_0000, id_valid=1, id_pc_plus4=4.
  - Edge 3: id_pc=8, fetch_count=3.
- stall high 2 cycles after edge 2: imem_pc stays 8, id_pc stays 4, fetch_count stays 2. On release, the next edge gives id_pc=8.
- redirect_valid=1, redirect_pc=0x40 with stall=1 simultaneously:
  - Next edge: imem_pc=0x40, id_valid=0.
  - Following edge: id_pc=0x40, id_instr=0x2000_0010.
- flush pulse alone at pc_q=0x10: id_valid=0 for one edge, imem_pc=0x14. Next edge: id_pc=0x14, id_valid=1.
- redirect_pc=0x42: fetch_fault=1, fault_cause=01, imem_pc unchanged, id_valid=0 for 10 further cycles. Asserting rst_n=0 mid-cycle clears all outputs immediately (asynchronously).
- Redirect to 0x3FC, then run:
  - Capture of 0x3FC gives id_valid=1.
  - Next edge (pc_q=0x400): fetch_fault=1, fault_cause=10.
  - A subsequent misaligned redirect leaves fault_cause=10.
